// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard control.
// Captures the decoder control bundle and operands for EX. It also:
//  - generates the load-use stall
//  - turns branch flushes into bubbles
//  - holds EX while a vector op waits for the CGRA issue handshake
// Saturating stall and vector-wait counters and a sticky timeout flag
// make stall behaviour visible to software and debug.
module id_ex_stage #(
   parameter int DATA_W   = 32,
   parameter int VTIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // ID stage
   input  logic              id_valid_i,
   input  logic              RegDst_i,
   input  logic              ALUSrc_i,
   input  logic              RegWrite_i,
   input  logic              MemRd_i,
   input  logic              MemWr_i,
   input  logic              VMemWr_i,
   input  logic              Branch_i,
   input  logic              MemToReg_i,
   input  logic              immSelect_i,
   input  logic [1:0]        ALUOp_i,
   input  logic              is_vec_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [4:0]        rd_i,
   input  logic [DATA_W-1:0] rs1_data_i,
   input  logic [DATA_W-1:0] rs2_data_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [DATA_W-1:0] pc_i,
   // hazard / handshake inputs
   input  logic              flush_i,
   input  logic              vec_ready_i,
   // upstream stall
   output logic              stall_o,
   // EX stage
   output logic              ex_valid_o,
   output logic              ex_is_vec_o,
   output logic              ex_RegDst_o,
   output logic              ex_ALUSrc_o,
   output logic              ex_RegWrite_o,
   output logic              ex_MemRd_o,
   output logic              ex_MemWr_o,
   output logic              ex_VMemWr_o,
   output logic              ex_Branch_o,
   output logic              ex_MemToReg_o,
   output logic              ex_immSelect_o,
   output logic [1:0]        ex_ALUOp_o,
   output logic [4:0]        ex_rs1_o,
   output logic [4:0]        ex_rs2_o,
   output logic [4:0]        ex_rd_o,
   output logic [DATA_W-1:0] ex_rs1_data_o,
   output logic [DATA_W-1:0] ex_rs2_data_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [DATA_W-1:0] ex_pc_o,
   // vector issue and status
   output logic              vec_valid_o,
   output logic              vwait_o,
   output logic [15:0]       stall_cnt_o,
   output logic              err_o
);

   localparam logic [15:0] VTIMEOUT_W = 16'(VTIMEOUT);
   localparam logic [15:0] CNT_MAX    = 16'hFFFF;

   typedef enum logic {
      RUN   = 1'b0,
      VWAIT = 1'b1
   } state_t;

   // Control bundle; all of it is cleared when a bubble is loaded.
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       reg_write;
      logic       mem_rd;
      logic       mem_wr;
      logic       vmem_wr;
      logic       branch;
      logic       mem_to_reg;
      logic       imm_select;
      logic [1:0] alu_op;
      logic       is_vec;
   } ctrl_t;

   ctrl_t             id_ctrl;
   ctrl_t             ex_ctrl_q, ex_ctrl_d;
   logic              ex_valid_q, ex_valid_d;
   logic [4:0]        ex_rs1_q, ex_rs1_d;
   logic [4:0]        ex_rs2_q, ex_rs2_d;
   logic [4:0]        ex_rd_q, ex_rd_d;
   logic [DATA_W-1:0] ex_rs1_data_q, ex_rs1_data_d;
   logic [DATA_W-1:0] ex_rs2_data_q, ex_rs2_data_d;
   logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
   logic [DATA_W-1:0] ex_pc_q, ex_pc_d;

   state_t            state_q, state_d;
   logic [15:0]       wait_cnt_q, wait_cnt_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;
   logic              err_q, err_d;

   logic              uses_rs2;
   logic              load_use;
   logic              vec_valid;
   logic              vec_hold;
   logic              stall;

   assign id_ctrl = {RegDst_i, ALUSrc_i, RegWrite_i, MemRd_i, MemWr_i, VMemWr_i,
                     Branch_i, MemToReg_i, immSelect_i, ALUOp_i, is_vec_i};

   // Hazard detection: rs1 is always a source; rs2 only when the op reads it.
   always_comb begin
      uses_rs2  = ~ALUSrc_i | MemWr_i | VMemWr_i | Branch_i;
      load_use  = id_valid_i & ex_valid_q & ex_ctrl_q.mem_rd & (ex_rd_q != 5'd0) &
                  ((ex_rd_q == rs1_i) | (uses_rs2 & (ex_rd_q == rs2_i)));
      vec_valid = ex_valid_q & ex_ctrl_q.is_vec;
      vec_hold  = vec_valid & ~vec_ready_i;
      // A flush discards ID anyway, so a load-use against it costs nothing.
      stall     = vec_hold | (load_use & ~flush_i);
   end

   // EX next state: hold for a waiting vector op, else load ID or a bubble.
   always_comb begin
      ex_valid_d    = ex_valid_q;
      ex_ctrl_d     = ex_ctrl_q;
      ex_rs1_d      = ex_rs1_q;
      ex_rs2_d      = ex_rs2_q;
      ex_rd_d       = ex_rd_q;
      ex_rs1_data_d = ex_rs1_data_q;
      ex_rs2_data_d = ex_rs2_data_q;
      ex_imm_d      = ex_imm_q;
      ex_pc_d       = ex_pc_q;
      if (!vec_hold) begin
         // Data fields are don't-care in a bubble, so they always follow ID.
         ex_rs1_d      = rs1_i;
         ex_rs2_d      = rs2_i;
         ex_rd_d       = rd_i;
         ex_rs1_data_d = rs1_data_i;
         ex_rs2_data_d = rs2_data_i;
         ex_imm_d      = imm_i;
         ex_pc_d       = pc_i;
         if (flush_i || load_use || !id_valid_i) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
         end else begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = id_ctrl;
         end
      end
   end

   // EX pipeline register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_valid_q    <= 1'b0;
         ex_ctrl_q     <= '0;
         ex_rs1_q      <= '0;
         ex_rs2_q      <= '0;
         ex_rd_q       <= '0;
         ex_rs1_data_q <= '0;
         ex_rs2_data_q <= '0;
         ex_imm_q      <= '0;
         ex_pc_q       <= '0;
      end else begin
         ex_valid_q    <= ex_valid_d;
         ex_ctrl_q     <= ex_ctrl_d;
         ex_rs1_q      <= ex_rs1_d;
         ex_rs2_q      <= ex_rs2_d;
         ex_rd_q       <= ex_rd_d;
         ex_rs1_data_q <= ex_rs1_data_d;
         ex_rs2_data_q <= ex_rs2_data_d;
         ex_imm_q      <= ex_imm_d;
         ex_pc_q       <= ex_pc_d;
      end
   end

   // Vector-wait FSM, wait counter, sticky timeout and stall counter next state.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      stall_cnt_d = stall_cnt_q;
      unique case (state_q)
         RUN: begin
            // An op accepted on its first EX cycle never reaches VWAIT.
            if (vec_hold) begin
               state_d = VWAIT;
            end
         end
         VWAIT: begin
            if (vec_ready_i) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: state_d = RUN;
      endcase
      // The op keeps waiting after a timeout; the flag only reports it.
      err_d = err_q | (wait_cnt_d >= VTIMEOUT_W);
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // FSM and status registers; reset drops any pending vector op.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign stall_o        = stall;
   assign ex_valid_o     = ex_valid_q;
   assign ex_is_vec_o    = ex_ctrl_q.is_vec;
   assign ex_RegDst_o    = ex_ctrl_q.reg_dst;
   assign ex_ALUSrc_o    = ex_ctrl_q.alu_src;
   assign ex_RegWrite_o  = ex_ctrl_q.reg_write;
   assign ex_MemRd_o     = ex_ctrl_q.mem_rd;
   assign ex_MemWr_o     = ex_ctrl_q.mem_wr;
   assign ex_VMemWr_o    = ex_ctrl_q.vmem_wr;
   assign ex_Branch_o    = ex_ctrl_q.branch;
   assign ex_MemToReg_o  = ex_ctrl_q.mem_to_reg;
   assign ex_immSelect_o = ex_ctrl_q.imm_select;
   assign ex_ALUOp_o     = ex_ctrl_q.alu_op;
   assign ex_rs1_o       = ex_rs1_q;
   assign ex_rs2_o       = ex_rs2_q;
   assign ex_rd_o        = ex_rd_q;
   assign ex_rs1_data_o  = ex_rs1_data_q;
   assign ex_rs2_data_o  = ex_rs2_data_q;
   assign ex_imm_o       = ex_imm_q;
   assign ex_pc_o        = ex_pc_q;
   assign vec_valid_o    = vec_valid;
   assign vwait_o        = (state_q == VWAIT);
   assign stall_cnt_o    = stall_cnt_q;
   assign err_o          = err_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage.
// Each cycle the expected EX content is queued as stimulus is driven.
// It is popped and compared one clock later.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int VT = 4;

   // control order: RegDst,ALUSrc,RegWrite,MemRd,MemWr,VMemWr,Branch,MemToReg,immSelect,ALUOp
   localparam logic [10:0] C_ADDI = 11'b0_1_1_0_0_0_0_0_1_10;
   localparam logic [10:0] C_ADD  = 11'b1_0_1_0_0_0_0_0_0_10;
   localparam logic [10:0] C_LW   = 11'b0_1_1_1_0_0_0_1_1_00;
   localparam logic [10:0] C_SW   = 11'b0_1_0_0_1_0_0_0_1_00;
   localparam logic [10:0] C_VEC  = 11'b0_0_0_0_0_1_0_0_0_11;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic id_valid_i = 1'b0;
   logic RegDst_i = 1'b0, ALUSrc_i = 1'b0, RegWrite_i = 1'b0, MemRd_i = 1'b0, MemWr_i = 1'b0;
   logic VMemWr_i = 1'b0, Branch_i = 1'b0, MemToReg_i = 1'b0, immSelect_i = 1'b0;
   logic [1:0] ALUOp_i = 2'b0;
   logic is_vec_i = 1'b0;
   logic [4:0] rs1_i = 5'd0, rs2_i = 5'd0, rd_i = 5'd0;
   logic [DW-1:0] rs1_data_i = '0, rs2_data_i = '0, imm_i = '0, pc_i = '0;
   logic flush_i = 1'b0, vec_ready_i = 1'b0;

   logic stall_o, ex_valid_o, ex_is_vec_o;
   logic ex_RegDst_o, ex_ALUSrc_o, ex_RegWrite_o, ex_MemRd_o, ex_MemWr_o;
   logic ex_VMemWr_o, ex_Branch_o, ex_MemToReg_o, ex_immSelect_o;
   logic [1:0] ex_ALUOp_o;
   logic [4:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
   logic [DW-1:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o;
   logic vec_valid_o, vwait_o, err_o;
   logic [15:0] stall_cnt_o;
   logic [10:0] obs_ctrl;

   always #5 clk_i = ~clk_i;

   id_ex_stage #(.DATA_W(DW), .VTIMEOUT(VT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
      .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i),
      .MemRd_i(MemRd_i), .MemWr_i(MemWr_i), .VMemWr_i(VMemWr_i),
      .Branch_i(Branch_i), .MemToReg_i(MemToReg_i), .immSelect_i(immSelect_i),
      .ALUOp_i(ALUOp_i), .is_vec_i(is_vec_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
      .flush_i(flush_i), .vec_ready_i(vec_ready_i), .stall_o(stall_o),
      .ex_valid_o(ex_valid_o), .ex_is_vec_o(ex_is_vec_o),
      .ex_RegDst_o(ex_RegDst_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_RegWrite_o(ex_RegWrite_o),
      .ex_MemRd_o(ex_MemRd_o), .ex_MemWr_o(ex_MemWr_o), .ex_VMemWr_o(ex_VMemWr_o),
      .ex_Branch_o(ex_Branch_o), .ex_MemToReg_o(ex_MemToReg_o),
      .ex_immSelect_o(ex_immSelect_o), .ex_ALUOp_o(ex_ALUOp_o),
      .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
      .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
      .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
      .vec_valid_o(vec_valid_o), .vwait_o(vwait_o),
      .stall_cnt_o(stall_cnt_o), .err_o(err_o)
   );

   assign obs_ctrl = {ex_RegDst_o, ex_ALUSrc_o, ex_RegWrite_o, ex_MemRd_o, ex_MemWr_o,
                      ex_VMemWr_o, ex_Branch_o, ex_MemToReg_o, ex_immSelect_o, ex_ALUOp_o};

   typedef struct {
      logic          valid;
      logic [10:0]   ctrl;
      logic          is_vec;
      logic [4:0]    rs1, rs2, rd;
      logic [DW-1:0] pc, imm, d1, d2;
   } exp_t;

   exp_t  sb_q[$];
   exp_t  cur_e;
   int    compared   = 0;
   int    mismatched = 0;
   logic [15:0] exp_stall_cnt = 16'd0;
   logic  exp_err = 1'b0;

   task automatic drive(input logic v, input logic [10:0] c, input logic vec,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic [DW-1:0] pc);
      id_valid_i = v;
      {RegDst_i, ALUSrc_i, RegWrite_i, MemRd_i, MemWr_i, VMemWr_i,
       Branch_i, MemToReg_i, immSelect_i, ALUOp_i} = c;
      is_vec_i   = vec;
      rs1_i      = r1;
      rs2_i      = r2;
      rd_i       = rd;
      pc_i       = pc;
      imm_i      = {pc[15:0], 11'h000, rd};
      rs1_data_i = pc ^ 32'hA5A5_0000;
      rs2_data_i = ~pc;
      cur_e.valid = v;  cur_e.ctrl = c;  cur_e.is_vec = vec;
      cur_e.rs1 = r1;   cur_e.rs2 = r2;  cur_e.rd = rd;
      cur_e.pc = pc;    cur_e.imm = imm_i;
      cur_e.d1 = rs1_data_i;  cur_e.d2 = rs2_data_i;
   endtask

   task automatic drive_nop();
      drive(1'b0, 11'h000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
   endtask

   task automatic push_id();
      sb_q.push_back(cur_e);
   endtask

   task automatic push_bubble();
      exp_t b;
      b.valid = 1'b0; b.ctrl = '0; b.is_vec = 1'b0;
      b.rs1 = '0; b.rs2 = '0; b.rd = '0; b.pc = '0; b.imm = '0; b.d1 = '0; b.d2 = '0;
      sb_q.push_back(b);
   endtask

   // One clock: check combinational stall mid-cycle, then pop the expected EX
   // content and compare it just after the edge.
   task automatic step(input logic exp_stall, input logic exp_vwait);
      exp_t e;
      #3;
      compared++;
      if (stall_o !== exp_stall) begin
         mismatched++;
         $display("FAIL stall_o @%0t: got %b want %b", $time, stall_o, exp_stall);
      end
      if (exp_stall && exp_stall_cnt != 16'hFFFF) exp_stall_cnt++;
      @(posedge clk_i);
      #1;
      compared++;
      if (sb_q.size() == 0) begin
         mismatched++;
         $display("FAIL scoreboard @%0t: queue empty, nothing expected", $time);
         return;
      end
      e = sb_q.pop_front();
      if (ex_valid_o !== e.valid || obs_ctrl !== e.ctrl || ex_is_vec_o !== e.is_vec) begin
         mismatched++;
         $display("FAIL ex_ctrl @%0t: got valid=%b ctrl=%b vec=%b want valid=%b ctrl=%b vec=%b",
                  $time, ex_valid_o, obs_ctrl, ex_is_vec_o, e.valid, e.ctrl, e.is_vec);
      end
      compared++;
      if (vec_valid_o !== (e.valid & e.is_vec)) begin
         mismatched++;
         $display("FAIL vec_valid_o @%0t: got %b want %b", $time, vec_valid_o, e.valid & e.is_vec);
      end
      if (e.valid) begin
         compared++;
         if (ex_rs1_o !== e.rs1 || ex_rs2_o !== e.rs2 || ex_rd_o !== e.rd ||
             ex_pc_o !== e.pc || ex_imm_o !== e.imm ||
             ex_rs1_data_o !== e.d1 || ex_rs2_data_o !== e.d2) begin
            mismatched++;
            $display("FAIL ex_data @%0t: got pc=%h rd=%0d imm=%h d1=%h want pc=%h rd=%0d imm=%h d1=%h",
                     $time, ex_pc_o, ex_rd_o, ex_imm_o, ex_rs1_data_o, e.pc, e.rd, e.imm, e.d1);
         end
      end
      compared++;
      if (vwait_o !== exp_vwait) begin
         mismatched++;
         $display("FAIL vwait_o @%0t: got %b want %b", $time, vwait_o, exp_vwait);
      end
      compared++;
      if (stall_cnt_o !== exp_stall_cnt) begin
         mismatched++;
         $display("FAIL stall_cnt_o @%0t: got %0d want %0d", $time, stall_cnt_o, exp_stall_cnt);
      end
      compared++;
      if (err_o !== exp_err) begin
         mismatched++;
         $display("FAIL err_o @%0t: got %b want %b", $time, err_o, exp_err);
      end
   endtask

   // Asserts reset mid-cycle and checks that it acts before any clock edge.
   task automatic test_reset();
      rst_i = 1'b0;
      #2;
      compared++;
      if (ex_valid_o !== 1'b0 || obs_ctrl !== 11'h000 || ex_is_vec_o !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_ctrl: got valid=%b ctrl=%b vec=%b want 0", ex_valid_o, obs_ctrl, ex_is_vec_o);
      end
      compared++;
      if (stall_o !== 1'b0 || vec_valid_o !== 1'b0 || vwait_o !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_hazard: got stall=%b vec_valid=%b vwait=%b want 0", stall_o, vec_valid_o, vwait_o);
      end
      compared++;
      if (stall_cnt_o !== 16'd0 || err_o !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_status: got stall_cnt=%0d err=%b want 0", stall_cnt_o, err_o);
      end
      compared++;
      if (ex_pc_o !== '0 || ex_rs1_data_o !== '0 || ex_imm_o !== '0 || ex_rd_o !== 5'd0) begin
         mismatched++;
         $display("FAIL reset_data: got pc=%h d1=%h imm=%h rd=%0d want 0", ex_pc_o, ex_rs1_data_o, ex_imm_o, ex_rd_o);
      end
      drive_nop();
      flush_i = 1'b0;
      vec_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      sb_q.delete();
      exp_stall_cnt = 16'd0;
      exp_err = 1'b0;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, C_ADDI, 1'b0, 5'd0, 5'd3, 5'd1, 32'h100 + 32'(4 * i));
         push_id();
         step(1'b0, 1'b0);
      end
      drive_nop(); push_bubble(); step(1'b0, 1'b0);
   endtask

   task automatic test_load_use();
      test_reset();
      // rs1 dependency
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd5, 32'h200); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADD, 1'b0, 5'd5, 5'd7, 5'd6, 32'h204); push_bubble(); step(1'b1, 1'b0);
      push_id(); step(1'b0, 1'b0);
      compared++;
      if (stall_cnt_o !== 16'd1) begin
         mismatched++;
         $display("FAIL load_use_cnt: got %0d want 1", stall_cnt_o);
      end
      // rs2 dependency of a register-register op
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd5, 32'h208); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADD, 1'b0, 5'd7, 5'd5, 5'd6, 32'h20C); push_bubble(); step(1'b1, 1'b0);
      push_id(); step(1'b0, 1'b0);
      // store data register (ALUSrc=1 but MemWr reads rs2)
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd5, 32'h210); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_SW, 1'b0, 5'd9, 5'd5, 5'd0, 32'h214); push_bubble(); step(1'b1, 1'b0);
      push_id(); step(1'b0, 1'b0);
      drive_nop(); push_bubble(); step(1'b0, 1'b0);
   endtask

   task automatic test_no_stall();
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd0, 32'h300); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADD, 1'b0, 5'd0, 5'd0, 5'd6, 32'h304); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd5, 32'h308); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADDI, 1'b0, 5'd8, 5'd5, 5'd6, 32'h30C); push_id(); step(1'b0, 1'b0);
      // invalid ID slot naming the load target: no stall, bubble loaded
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd5, 32'h310); push_id(); step(1'b0, 1'b0);
      drive(1'b0, C_ADD, 1'b0, 5'd5, 5'd5, 5'd6, 32'h314); push_bubble(); step(1'b0, 1'b0);
      drive_nop(); push_bubble(); step(1'b0, 1'b0);
   endtask

   task automatic test_vector();
      exp_t v;
      exp_t a;
      logic [15:0] base;
      base = exp_stall_cnt;
      // three cycles of waiting, handshake on the fourth
      vec_ready_i = 1'b0;
      drive(1'b1, C_VEC, 1'b1, 5'd1, 5'd2, 5'd3, 32'h400); v = cur_e; push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd7, 32'h404); a = cur_e;
      for (int k = 0; k < 3; k++) begin
         sb_q.push_back(v);
         step(1'b1, 1'b1);
      end
      vec_ready_i = 1'b1; sb_q.push_back(a); step(1'b0, 1'b0);
      vec_ready_i = 1'b0; drive_nop(); push_bubble(); step(1'b0, 1'b0);
      compared++;
      if (stall_cnt_o !== base + 16'd3) begin
         mismatched++;
         $display("FAIL vec_stall_cnt: got %0d want %0d", stall_cnt_o, base + 16'd3);
      end
      // handshake on the first EX cycle: zero stall, no VWAIT
      drive(1'b1, C_VEC, 1'b1, 5'd4, 5'd5, 5'd6, 32'h410); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd8, 32'h414); vec_ready_i = 1'b1;
      push_id(); step(1'b0, 1'b0);
      vec_ready_i = 1'b0; drive_nop(); push_bubble(); step(1'b0, 1'b0);
      // flush during the wait must leave EX untouched
      drive(1'b1, C_VEC, 1'b1, 5'd7, 5'd8, 5'd9, 32'h420); v = cur_e; push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd10, 32'h424); a = cur_e;
      flush_i = 1'b1; sb_q.push_back(v); step(1'b1, 1'b1);
      sb_q.push_back(v); step(1'b1, 1'b1);
      flush_i = 1'b0; vec_ready_i = 1'b1; sb_q.push_back(a); step(1'b0, 1'b0);
      vec_ready_i = 1'b0; drive_nop(); push_bubble(); step(1'b0, 1'b0);
   endtask

   task automatic test_flush();
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd5, 32'h500); push_id(); step(1'b0, 1'b0);
      // flush together with a load-use: bubble, no stall
      drive(1'b1, C_ADD, 1'b0, 5'd5, 5'd7, 5'd6, 32'h504); flush_i = 1'b1;
      push_bubble(); step(1'b0, 1'b0);
      flush_i = 1'b0;
      drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd9, 32'h508); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd11, 32'h50C); flush_i = 1'b1;
      push_bubble(); step(1'b0, 1'b0);
      flush_i = 1'b0; drive_nop(); push_bubble(); step(1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      exp_t v;
      int   low;
      test_reset();
      drive(1'b1, C_VEC, 1'b1, 5'd1, 5'd2, 5'd3, 32'h600); v = cur_e; push_id(); step(1'b0, 1'b0);
      drive_nop();
      low = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i >= 2) low++;           // cycles spent in VWAIT without a handshake
         exp_err = (low >= VT);
         sb_q.push_back(v);
         step(1'b1, 1'b1);
      end
      compared++;
      if (err_o !== 1'b1) begin
         mismatched++;
         $display("FAIL timeout_err: got %b want 1", err_o);
      end
      vec_ready_i = 1'b1; push_bubble(); step(1'b0, 1'b0);
      vec_ready_i = 1'b0; push_bubble(); step(1'b0, 1'b0);
      compared++;
      if (err_o !== 1'b1 || stall_cnt_o !== 16'd10) begin
         mismatched++;
         $display("FAIL timeout_sticky: got err=%b cnt=%0d want err=1 cnt=10", err_o, stall_cnt_o);
      end
      test_reset();
   endtask

   task automatic test_reset_mid_vwait();
      exp_t v;
      drive(1'b1, C_VEC, 1'b1, 5'd1, 5'd2, 5'd3, 32'h700); v = cur_e; push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADDI, 1'b0, 5'd1, 5'd0, 5'd4, 32'h704);
      sb_q.push_back(v); step(1'b1, 1'b1);
      sb_q.push_back(v); step(1'b1, 1'b1);
      test_reset();
      drive_nop(); push_bubble(); step(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      // dependent loads chained: each consumer stalls exactly once
      drive(1'b1, C_LW, 1'b0, 5'd2, 5'd0, 5'd5, 32'h800); push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_LW, 1'b0, 5'd5, 5'd0, 5'd6, 32'h804); push_bubble(); step(1'b1, 1'b0);
      push_id(); step(1'b0, 1'b0);
      drive(1'b1, C_ADD, 1'b0, 5'd6, 5'd6, 5'd7, 32'h808); push_bubble(); step(1'b1, 1'b0);
      push_id(); step(1'b0, 1'b0);
      drive_nop(); push_bubble(); step(1'b0, 1'b0);
   endtask

   initial begin
      drive_nop();
      #1;
      @(posedge clk_i);
      #1;
      test_reset();
      test_stream();
      test_load_use();
      test_no_stall();
      test_vector();
      test_flush();
      test_back_to_back();
      test_timeout();
      test_reset_mid_vwait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with hazard control for the vector-extended RISC-V pipeline. It captures the decoder's control bundle plus operands each cycle and hands them to EX. It also generates the load-use stall, applies branch flushes as bubbles, and holds EX while a vector op (opcode 1010111) waits for the CGRA issue handshake. Saturating stall and vector-wait counters plus a sticky timeout flag expose stall behaviour to software and debug.

## Interface
- DATA_W, 32, operand/immediate/PC width
- VTIMEOUT, 255, vector-wait cycles before err_o sets (1..65535)
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_valid_i  in  1  ID slot holds a real instruction
- RegDst_i, ALUSrc_i, RegWrite_i, MemRd_i, MemWr_i, VMemWr_i, Branch_i, MemToReg_i, immSelect_i  in  1 each  decoder control bits
- ALUOp_i  in  2  decoder ALU class
- is_vec_i  in  1  opcode == 1010111
- rs1_i, rs2_i, rd_i  in  5 each  register indices
- rs1_data_i, rs2_data_i, imm_i, pc_i  in  DATA_W each  operands
- flush_i  in  1  branch taken in EX; discard ID
- vec_ready_i  in  1  CGRA accepts vector op
- stall_o  out  1  hold PC and IF/ID (combinational)
- ex_valid_o, ex_is_vec_o, ex_<ctrl>_o  out  as inputs  registered copies of every control input
- ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o  out  as inputs  registered operands
- vec_valid_o  out  1  = ex_valid_o & ex_is_vec_o
- vwait_o  out  1  FSM in VWAIT
- stall_cnt_o  out  16  saturating count of cycles with stall_o=1
- err_o  out  1  sticky vector timeout

## Operation
- uses_rs2 = ~ALUSrc_i | MemWr_i | VMemWr_i | Branch_i; rs1 is always treated as used.
- load_use = id_valid_i & ex_valid_o & ex_MemRd_o & (ex_rd_o != 0) & (ex_rd_o == rs1_i | (uses_rs2 & ex_rd_o == rs2_i)).
- vec_hold = vec_valid_o & ~vec_ready_i.
- stall_o = vec_hold | (load_use & ~flush_i).
- EX register update, priority order:
  - 1. vec_hold: hold all ex_* unchanged.
  - 2. flush_i: load a bubble.
  - 3. load_use: load a bubble.
  - 4. Otherwise: load ID fields if id_valid_i, else a bubble.
- A bubble sets ex_valid_o=0 and every control bit and ex_is_vec_o to 0. Data fields may take any value.
- flush_i is ignored while vec_hold=1: a branch cannot occupy EX alongside a vector op.
- FSM states RUN and VWAIT.
  - RUN→VWAIT when vec_hold=1.
  - VWAIT→RUN on the cycle vec_ready_i=1 (handshake), which releases EX that same edge.
  - A vector op accepted on its first EX cycle never enters VWAIT.
- wait_cnt (16b) increments each VWAIT cycle and clears on handshake.
  - err_o sets when wait_cnt reaches VTIMEOUT and stays set until reset.
  - The op keeps waiting; there is no abort.
- stall_cnt_o increments on each stall_o=1 cycle and saturates at 0xFFFF.

## Timing
- Reset (rst_i=0, async): ex_valid_o=0, all ex_* control=0, ex data=0, state=RUN, wait_cnt=0, stall_cnt_o=0, err_o=0. Hence stall_o=0 and vec_valid_o=0.
- Deassertion is sampled by the next rising edge.
- Reset asserted mid-VWAIT drops the pending vector op without a handshake.
- Normal latency: ID fields appear on ex_*_o one cycle after the edge that samples them.
- Load-use costs exactly 1 bubble. Next cycle EX holds the bubble, load_use=0, and the held ID instruction advances.
- Vector issue: ex_* stays stable from the first vec_valid_o cycle through the handshake cycle inclusive.
- A handshake in the first cycle gives zero stall.
- Simultaneous flush_i and load_use: the bubble is loaded, stall_o=0, and ID is discarded (the upstream IF/ID flush handles it).

## Test plan
- Reset then stream: addi x1 with id_valid_i=1 each cycle → ex_valid_o=1 and ex_RegWrite_o=1 one cycle later; stall_o never 1.
- lw x5 then add x6,x5,x7 back-to-back → stall_o=1 for exactly 1 cycle, a bubble in EX, add reaches EX 2 cycles after lw; stall_cnt_o=1.
- lw x0 then add using x0, and lw x5 then addi x6,x8 with rs2_i=5 (ALUSrc_i=1) → no stall in either case.
- Vector op in EX with vec_ready_i low 3 cycles, high on the 4th → vec_valid_o=1 for 4 cycles, vwait_o=1 for 3, stall_o=1 for 3, ex_* stable, stall_cnt_o+=3.
- VTIMEOUT=4, vec_ready_i held 0 for 10 cycles → err_o rises after 4 VWAIT cycles and stays 1 after the handshake; rst_i low clears it.
- flush_i=1 with a valid ID instruction (including a load_use condition) → next cycle ex_valid_o=0 and stall_o=0 in the flush cycle; a flush during VWAIT leaves EX unchanged.
